// File: rtl/gb_framebuffer_if.sv
// PPU-side pixel write port for gb_framebuffer.
// master = PPU (drives pixels), slave = framebuffer (returns wr_ready).
interface gb_framebuffer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_x;
  logic [7:0] wr_y;
  logic [1:0] wr_shade;
  logic       wr_frame_end;

  modport master (
    output wr_valid,
    output wr_x,
    output wr_y,
    output wr_shade,
    output wr_frame_end,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_x,
    input  wr_y,
    input  wr_shade,
    input  wr_frame_end,
    output wr_ready
  );
endinterface

// File: rtl/gb_framebuffer.sv
// Game Boy framebuffer: PPU writes 2-bit shades, HDMI reads RGB.
// Ports: clock25mhz, resetn (sync, low), wr (gb_framebuffer_if.slave:
//   wr_valid/wr_ready/wr_x/wr_y/wr_shade/wr_frame_end), rd_x/rd_y in,
//   r/g/b out READ_LATENCY cycles after rd_x/rd_y, frame_swapped pulse,
//   wr_error sticky out-of-range write flag.
// Define FB_DOUBLE_BUFFER_EN for front/back banks; default is one bank
// written in place (tearing possible, front never changes).
module gb_framebuffer #(
  parameter int          WIDTH        = 160,
  parameter int          HEIGHT       = 144,
  parameter int          READ_LATENCY = 2,
  parameter logic [23:0] PAL0         = 24'hE0F8D0,
  parameter logic [23:0] PAL1         = 24'h88C070,
  parameter logic [23:0] PAL2         = 24'h346856,
  parameter logic [23:0] PAL3         = 24'h081820
) (
  input  logic              clock25mhz,
  input  logic              resetn,
  gb_framebuffer_if.slave   wr,
  input  logic [11:0]       rd_x,
  input  logic [11:0]       rd_y,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              frame_swapped,
  output logic              wr_error
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = $clog2(NPIX);

  typedef enum logic {
    FILL,
    PENDING
  } state_t;

  state_t state;

`ifdef FB_DOUBLE_BUFFER_EN
  logic       front;
  logic [1:0] mem [2][NPIX];
`else
  logic [1:0] mem [NPIX];
`endif

  // ---------------- write side ----------------
  logic          wr_fire;
  logic          wr_in;
  logic          wr_we;
  logic [AW-1:0] wr_addr;

  assign wr.wr_ready = (state == FILL);
  assign wr_fire = wr.wr_valid && wr.wr_ready;
  assign wr_in   = (32'(wr.wr_x) < WIDTH)
                && (32'(wr.wr_y) < HEIGHT);
  // Blocked while resetn is low so a write can't land
  // in a bank that reset is about to discard.
  assign wr_we   = resetn && wr_fire && wr_in;
  assign wr_addr = wr_in
                 ? AW'(32'(wr.wr_y) * WIDTH + 32'(wr.wr_x))
                 : '0;

  // ---------------- read side ----------------
  logic          rd_ok;
  logic [AW-1:0] rd_addr;
  logic [11:0]   rd_y_q;
  logic          boundary;

  assign rd_ok   = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
  assign rd_addr = rd_ok
                 ? AW'(32'(rd_y) * WIDTH + 32'(rd_x))
                 : '0;
  // Display wraps from the last line back to line 0.
  assign boundary = (rd_y_q == 12'(HEIGHT - 1)) && (rd_y == 12'd0);

  // ---------------- frame pacing FSM ----------------
  always_ff @(posedge clock25mhz) begin
    if (!resetn) begin
      state         <= FILL;
      frame_swapped <= 1'b0;
      wr_error      <= 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
      front         <= 1'b0;
`endif
    end else begin
      frame_swapped <= 1'b0;
      if (wr_fire && !wr_in)
        wr_error <= 1'b1;
      unique case (state)
        FILL: begin
          // A boundary in the same cycle only arms the swap;
          // it happens at the next boundary.
          if (wr.wr_frame_end)
            state <= PENDING;
        end
        PENDING: begin
          if (boundary) begin
`ifdef FB_DOUBLE_BUFFER_EN
            front <= ~front;
`endif
            frame_swapped <= 1'b1;
            state         <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // ---------------- pixel memory ----------------
  // No reset: plain RAM. Read-before-write on a shared
  // address returns the old shade.
  logic [1:0] s1_shade;

  always_ff @(posedge clock25mhz) begin
`ifdef FB_DOUBLE_BUFFER_EN
    if (wr_we)
      mem[~front][wr_addr] <= wr.wr_shade;
    s1_shade <= mem[front][rd_addr];
`else
    if (wr_we)
      mem[wr_addr] <= wr.wr_shade;
    s1_shade <= mem[rd_addr];
`endif
  end

  // ---------------- palette + delay line ----------------
  logic        s1_ok;
  logic [23:0] pal_rgb;
  logic [23:0] pipe [READ_LATENCY-1];

  always_comb begin
    pal_rgb = 24'd0;
    unique case (1'b1)
      (s1_shade == 2'd0): pal_rgb = PAL0;
      (s1_shade == 2'd1): pal_rgb = PAL1;
      (s1_shade == 2'd2): pal_rgb = PAL2;
      (s1_shade == 2'd3): pal_rgb = PAL3;
      default:            pal_rgb = 24'd0;
    endcase
  end

  always_ff @(posedge clock25mhz) begin
    if (!resetn) begin
      s1_ok  <= 1'b0;
      rd_y_q <= 12'd0;
      for (int i = 0; i < READ_LATENCY - 1; i++)
        pipe[i] <= 24'd0;
    end else begin
      s1_ok   <= rd_ok;
      rd_y_q  <= rd_y;
      pipe[0] <= s1_ok ? pal_rgb : 24'd0;
      for (int i = 1; i < READ_LATENCY - 1; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign {r, g, b} = pipe[READ_LATENCY-2];

endmodule

// File: doc/gb_framebuffer.md
Name: gb_framebuffer

Overview:
Pixel store between the Game Boy PPU and the HDMI output stage. The PPU writes 2-bit shade pixels through a valid/ready port. The HDMI stage supplies scan coordinates (rd_x, rd_y) and receives 24-bit RGB after a fixed latency equal to its CYCLE_DELAY. Two banks (front/back) are swapped only at a display frame boundary, so a frame is never shown half-written.

Parameters:
WIDTH, 160, pixels per line
HEIGHT, 144, lines per frame
READ_LATENCY, 2, cycles from rd_x/rd_y to r/g/b; must be >= 2 and equal to the HDMI stage CYCLE_DELAY
PAL0, 24'hE0F8D0, RGB for shade 0 (lightest)
PAL1, 24'h88C070, RGB for shade 1
PAL2, 24'h346856, RGB for shade 2
PAL3, 24'h081820, RGB for shade 3 (darkest)

Ports:
clock25mhz  in  1  sole clock
resetn  in  1  synchronous active-low reset
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_x  in  8  write column
wr_y  in  8  write row
wr_shade  in  2  pixel shade
wr_frame_end  in  1  one-cycle pulse: back buffer complete
rd_x  in  12  display read column
rd_y  in  12  display read row
r  out  8  red, READ_LATENCY after rd_x/rd_y
g  out  8  green
b  out  8  blue
frame_swapped  out  1  one-cycle pulse on bank swap
wr_error  out  1  sticky flag: out-of-range write seen

Behaviour:
- Reset (resetn low at a clock edge) sets state FILL, front=0, r/g/b=0, frame_swapped=0, wr_error=0, and clears the read pipeline. Memory contents are not reset.
- wr_ready = (state==FILL). It is combinational from state and is 1 in the first cycle after reset.
- Write accept:
  - In range (wr_x<WIDTH, wr_y<HEIGHT): store wr_shade at address wr_y*WIDTH+wr_x in the back bank.
  - Out of range: consumed, nothing stored, wr_error set to 1. wr_error clears only on reset.
- wr_valid while wr_ready=0: ignored and not stored.
- FILL state: wr_frame_end=1 moves the block to PENDING at the next edge.
  - A write accepted in the same cycle as wr_frame_end is stored.
- Display frame boundary = registered rd_y equals HEIGHT-1 and current rd_y equals 0.
- PENDING state: at a boundary, front <= ~front, frame_swapped=1 for one cycle, state <= FILL.
- A boundary seen while in FILL causes no swap; the old frame repeats.
- wr_frame_end in PENDING is ignored.
- wr_frame_end in the same cycle as a boundary while in FILL: go to PENDING only. The swap happens at the following boundary.
- Read pipeline:
  - Stage 1 registers the shade from the front bank, plus an in-range flag (rd_x<WIDTH && rd_y<HEIGHT).
  - Stage 2 registers PALn as {r,g,b}, or 0 when out of range.
  - Stages 3..READ_LATENCY are pure delay.
  - Exactly one result per cycle; continuous throughput.
- A write and a read cannot hit the same bank, because writes go only to the back bank.
- Address arithmetic uses ceil(log2(WIDTH*HEIGHT)) bits, unsigned. Comparisons are done on the full 12-bit read coordinates, so values above 255 are treated as out of range.
- Reset while PENDING: returns to FILL, front=0, and any back-bank frame is discarded.

Optional Feature:
FB_DOUBLE_BUFFER_EN
- Defined: two banks (2*WIDTH*HEIGHT*2 bits), with behaviour as above.
- Undefined:
  - A single bank is used, and writes go straight to the displayed bank, so tearing is possible.
  - The FILL/PENDING pacing and frame_swapped pulse are unchanged, but front never changes.
  - A read and a write to the same address in the same cycle returns the old shade.

Test Plan:
- Reset -> r=g=b=0, frame_swapped=0, wr_error=0, wr_ready=1 on the cycle after resetn rises.
- Write (5,7) shade 2, then pulse wr_frame_end, then drive rd_y 143->0 -> frame_swapped=1 for one cycle. A later read at (5,7) gives r=0x34 g=0x68 b=0x56 exactly 2 cycles after the address.
- Same write but reading (5,7) before the boundary -> old front-bank value. After the swap -> 0x346856. With FB_DOUBLE_BUFFER_EN undefined, the read gives 0x346856 immediately.
- After wr_frame_end: wr_ready=0. A wr_valid write of (0,0) shade 3 is not stored; after the swap, (0,0) keeps its previous value.
- Write (160,0) -> wr_error=1, no memory change. Read at rd_x=200 -> rgb=0 after 2 cycles.
- Assert resetn=0 while PENDING -> next cycle state FILL, wr_ready=1, and no frame_swapped at the following boundary without a new wr_frame_end.
